// File: rtl/conf_int_add_err_monitor_if.sv
// Operand/result triple stream from the adder driver into the error monitor.
// One triple moves on each cycle where s_valid and s_ready are both high.
interface conf_int_add_err_monitor_if #(
    parameter int OP_BITWIDTH = 32
);
    logic                   s_valid;
    logic                   s_ready;
    logic [OP_BITWIDTH-1:0] a;
    logic [OP_BITWIDTH-1:0] b;
    logic [OP_BITWIDTH-1:0] d;

    modport master (output s_valid, output a, output b, output d, input s_ready);
    modport slave  (input s_valid, input a, input b, input d, output s_ready);
endinterface

// File: rtl/conf_int_add_err_monitor.sv
// Compares adder results against a+b and accumulates error statistics over a run of NUM_SAMPLES triples.
// Statistics update on the edge after acceptance; s_ready only in RUN until NUM_SAMPLES triples are taken.
module conf_int_add_err_monitor #(
    parameter int OP_BITWIDTH = 32,
    parameter int NUM_SAMPLES = 500,
    parameter int ERR_THRESH  = 0
) (
    input  logic                        clk,
    input  logic                        racc,
    input  logic                        start,
    conf_int_add_err_monitor_if.slave   samples,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 sample_cnt,
    output logic [15:0]                 mismatch_cnt,
    output logic [OP_BITWIDTH-1:0]      max_err,
    output logic [47:0]                 sum_err,
    output logic [15:0]                 first_bad_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ready;
    logic                   clear;
    logic                   accept;
    logic [31:0]            acc_cnt;
    logic                   s1_vld;
    logic [OP_BITWIDTH-1:0] s1_abs;
    logic [15:0]            s1_idx;
    logic [OP_BITWIDTH-1:0] exact;
    logic signed [OP_BITWIDTH:0] diff;
    logic [OP_BITWIDTH-1:0] abs_now;
    logic [15:0]            idx_now;
    logic [48:0]            sum_nxt;

    assign samples.s_ready = ready;
    assign accept          = samples.s_valid && ready;

    always_ff @(posedge clk) begin
        if (!racc) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                ready = acc_cnt < 32'(NUM_SAMPLES);
                if (accept && acc_cnt == 32'(NUM_SAMPLES - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_vld) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Error is measured on the wrapped sum, both sides taken as signed values.
    always_comb begin
        exact   = samples.a + samples.b;
        diff    = $signed({exact[OP_BITWIDTH-1], exact}) - $signed({samples.d[OP_BITWIDTH-1], samples.d});
        abs_now = diff[OP_BITWIDTH] ? OP_BITWIDTH'(-diff) : OP_BITWIDTH'(diff);
        idx_now = (|acc_cnt[31:16]) ? 16'hFFFF : acc_cnt[15:0];
        sum_nxt = {1'b0, sum_err} + 49'(s1_abs);
    end

    always_ff @(posedge clk) begin
        if (!racc) begin
            acc_cnt       <= '0;
            s1_vld        <= 1'b0;
            s1_abs        <= '0;
            s1_idx        <= '0;
            sample_cnt    <= '0;
            mismatch_cnt  <= '0;
            max_err       <= '0;
            sum_err       <= '0;
            first_bad_idx <= 16'hFFFF;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_abs  <= abs_now;
                s1_idx  <= idx_now;
                acc_cnt <= acc_cnt + 32'd1;
            end
            if (clear) begin
                acc_cnt       <= '0;
                sample_cnt    <= '0;
                mismatch_cnt  <= '0;
                max_err       <= '0;
                sum_err       <= '0;
                first_bad_idx <= 16'hFFFF;
            end else if (s1_vld) begin
                if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
                sum_err <= sum_nxt[48] ? {48{1'b1}} : sum_nxt[47:0];
                if (s1_abs > max_err) max_err <= s1_abs;
                if (s1_abs > OP_BITWIDTH'(ERR_THRESH)) begin
                    if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
                    if (first_bad_idx == 16'hFFFF) first_bad_idx <= s1_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_conf_int_add_err_monitor.sv
// Two monitor instances (4 samples / threshold 0, 500 samples / threshold 4) checked against a run-level model.
module tb_conf_int_add_err_monitor;
    localparam int NS [2] = '{4, 500};
    localparam int TH [2] = '{0, 4};

    typedef struct packed {
        logic [1:0]  phase;   // 0 idle, 1 taking samples, 2 finishing, 3 finished
        logic [31:0] acc;
        logic        pend;
        logic [63:0] pabs;
        logic [15:0] pidx;
        logic [15:0] scnt;
        logic [15:0] mcnt;
        logic [63:0] maxe;
        logic [63:0] sume;
        logic [15:0] first;
    } model_t;

    logic        clk = 1'b0;
    logic        racc = 1'b0;
    logic        chk_en = 1'b0;
    logic [1:0]  start_r = '0;
    logic [1:0]  vld_r = '0;
    logic [31:0] a_r [2];
    logic [31:0] b_r [2];
    logic [31:0] d_r [2];
    logic [1:0]  rdy;
    logic [1:0]  busy_o;
    logic [1:0]  done_o;
    logic [15:0] scnt_o [2];
    logic [15:0] mcnt_o [2];
    logic [31:0] maxe_o [2];
    logic [47:0] sume_o [2];
    logic [15:0] first_o [2];
    model_t      m [2];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    conf_int_add_err_monitor_if #(.OP_BITWIDTH(32)) bus_a ();
    conf_int_add_err_monitor_if #(.OP_BITWIDTH(32)) bus_b ();

    assign bus_a.s_valid = vld_r[0];
    assign bus_a.a = a_r[0];
    assign bus_a.b = b_r[0];
    assign bus_a.d = d_r[0];
    assign rdy[0] = bus_a.s_ready;
    assign bus_b.s_valid = vld_r[1];
    assign bus_b.a = a_r[1];
    assign bus_b.b = b_r[1];
    assign bus_b.d = d_r[1];
    assign rdy[1] = bus_b.s_ready;

    conf_int_add_err_monitor #(.OP_BITWIDTH(32), .NUM_SAMPLES(4), .ERR_THRESH(0)) u_a (
        .clk(clk), .racc(racc), .start(start_r[0]), .samples(bus_a),
        .busy(busy_o[0]), .done(done_o[0]), .sample_cnt(scnt_o[0]), .mismatch_cnt(mcnt_o[0]),
        .max_err(maxe_o[0]), .sum_err(sume_o[0]), .first_bad_idx(first_o[0]));

    conf_int_add_err_monitor #(.OP_BITWIDTH(32), .NUM_SAMPLES(500), .ERR_THRESH(4)) u_b (
        .clk(clk), .racc(racc), .start(start_r[1]), .samples(bus_b),
        .busy(busy_o[1]), .done(done_o[1]), .sample_cnt(scnt_o[1]), .mismatch_cnt(mcnt_o[1]),
        .max_err(maxe_o[1]), .sum_err(sume_o[1]), .first_bad_idx(first_o[1]));

    function automatic model_t m_reset();
        model_t r = '0;
        r.first = 16'hFFFF;
        return r;
    endfunction

    function automatic logic [63:0] ref_abs(logic [31:0] ta, logic [31:0] tb, logic [31:0] td);
        logic [31:0] e = ta + tb;
        longint diff = longint'($signed(e)) - longint'($signed(td));
        return (diff < 0) ? 64'(-diff) : 64'(diff);
    endfunction

    function automatic model_t step(model_t s, logic rst_n, logic st, logic v,
                                    logic [31:0] ta, logic [31:0] tb, logic [31:0] td, int n, int th);
        model_t r = s;
        if (!rst_n) return m_reset();
        if (s.pend) begin
            if (r.scnt != 16'hFFFF) r.scnt = r.scnt + 16'd1;
            r.sume = (s.sume + s.pabs > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : s.sume + s.pabs;
            if (s.pabs > r.maxe) r.maxe = s.pabs;
            if (s.pabs > 64'(th)) begin
                if (r.mcnt != 16'hFFFF) r.mcnt = r.mcnt + 16'd1;
                if (r.first == 16'hFFFF) r.first = s.pidx;
            end
        end
        r.pend = 1'b0;
        case (s.phase)
            2'd0, 2'd3: if (st) begin
                r = m_reset();
                r.phase = 2'd1;
            end
            2'd1: if (v && s.acc < 32'(n)) begin
                r.pend = 1'b1;
                r.pabs = ref_abs(ta, tb, td);
                r.pidx = s.acc[15:0];
                r.acc  = s.acc + 32'd1;
                if (r.acc == 32'(n)) r.phase = 2'd2;
            end
            default: if (!s.pend) r.phase = 2'd3;
        endcase
        return r;
    endfunction

    task automatic check(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", k, nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            m[k] = step(m[k], racc, start_r[k], vld_r[k], a_r[k], b_r[k], d_r[k], NS[k], TH[k]);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check(k, "s_ready", 64'(rdy[k]), 64'(m[k].phase == 2'd1 && m[k].acc < 32'(NS[k])));
                check(k, "busy", 64'(busy_o[k]), 64'(m[k].phase == 2'd1 || m[k].phase == 2'd2));
                check(k, "done", 64'(done_o[k]), 64'(m[k].phase == 2'd3));
                check(k, "sample_cnt", 64'(scnt_o[k]), 64'(m[k].scnt));
                check(k, "mismatch_cnt", 64'(mcnt_o[k]), 64'(m[k].mcnt));
                check(k, "max_err", 64'(maxe_o[k]), m[k].maxe);
                check(k, "sum_err", 64'(sume_o[k]), m[k].sume);
                check(k, "first_bad_idx", 64'(first_o[k]), 64'(m[k].first));
            end
        end
    end

    task automatic pulse_start(input int k);
        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] td);
        logic r = 1'b0;
        a_r[k] = ta; b_r[k] = tb; d_r[k] = td; vld_r[k] = 1'b1;
        for (int i = 0; i < 50 && !r; i++) begin
            @(negedge clk); r = rdy[k];
            @(posedge clk); #1;
        end
        vld_r[k] = 1'b0;
        if (!r) check(k, "accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_o[k]) break;
        end
        check(k, "done_reached", 64'(done_o[k]), 64'd1);
    endtask

    task automatic check_stats(input int k, input logic [15:0] sc, input logic [15:0] mc,
                               input logic [31:0] mx, input logic [47:0] sm, input logic [15:0] fb);
        check(k, "lit_sample_cnt", 64'(scnt_o[k]), 64'(sc));
        check(k, "lit_mismatch_cnt", 64'(mcnt_o[k]), 64'(mc));
        check(k, "lit_max_err", 64'(maxe_o[k]), 64'(mx));
        check(k, "lit_sum_err", 64'(sume_o[k]), 64'(sm));
        check(k, "lit_first_bad_idx", 64'(first_o[k]), 64'(fb));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            a_r[k] = '0; b_r[k] = '0; d_r[k] = '0;
            m[k] = m_reset();
        end
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        racc = 1'b1;
        @(negedge clk);
        check_stats(0, 16'd0, 16'd0, 32'd0, 48'd0, 16'hFFFF);
        check(0, "lit_reset_busy", 64'(busy_o[0]), 64'd0);

        // Valid while idle must be ignored.
        vld_r[0] = 1'b1; a_r[0] = 32'd3; b_r[0] = 32'd4; d_r[0] = 32'd0;
        repeat (3) @(posedge clk);
        #1 vld_r[0] = 1'b0;

        // Exact results.
        pulse_start(0);
        send(0, 32'd1, 32'd2, 32'd3);
        send(0, 32'd1000, 32'd24, 32'd1024);
        send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        send(0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
        wait_done(0);
        check_stats(0, 16'd4, 16'd0, 32'd0, 48'd0, 16'hFFFF);

        // Error injection, with an ignored start mid-run.
        pulse_start(0);
        send(0, 32'd10, 32'd5, 32'd15);
        pulse_start(0);
        send(0, 32'd10, 32'd5, 32'd12);
        send(0, -32'sd3, -32'sd4, -32'sd7);
        send(0, 32'd100, 32'd1, 32'd109);
        wait_done(0);
        check_stats(0, 16'd4, 16'd2, 32'd8, 48'd11, 16'd1);

        // Signed overflow wrap and the largest possible error.
        pulse_start(0);
        send(0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        send(0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        send(0, 32'h8000_0000, 32'h8000_0000, 32'd0);
        send(0, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000);
        wait_done(0);
        check_stats(0, 16'd4, 16'd1, 32'hFFFF_FFFF, 48'h0000_FFFF_FFFF, 16'd3);

        // Reset mid-run discards in-flight triples.
        pulse_start(0);
        send(0, 32'd1, 32'd1, 32'd9);
        send(0, 32'd2, 32'd2, 32'd0);
        send(0, 32'd3, 32'd3, 32'd1);
        racc = 1'b0;
        repeat (20) @(posedge clk);
        #1 racc = 1'b1;
        repeat (3) @(negedge clk);
        check_stats(0, 16'd0, 16'd0, 32'd0, 48'd0, 16'hFFFF);
        check(0, "lit_post_reset_busy", 64'(busy_o[0]), 64'd0);
        check(0, "lit_post_reset_done", 64'(done_o[0]), 64'd0);
        pulse_start(0);
        for (int i = 0; i < 4; i++) send(0, 32'(i), 32'd7, 32'(i + 7));
        wait_done(0);
        check_stats(0, 16'd4, 16'd0, 32'd0, 48'd0, 16'hFFFF);

        // 500 samples with random gaps; errors 3, 4, 5 against threshold 4.
        pulse_start(1);
        for (int i = 0; i < 500; i++) begin
            logic [31:0] ra, rb, ex;
            int g;
            g = ($urandom_range(0, 3) > 1) ? int'($urandom_range(1, 2)) : 0;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            ra = $urandom; rb = $urandom; ex = ra + rb;
            case (i)
                0: send(1, ra, rb, ex - 32'd3);
                1: send(1, ra, rb, ex + 32'd4);
                2: send(1, ra, rb, ex - 32'd5);
                default: send(1, ra, rb, ex);
            endcase
        end
        @(negedge clk);
        check(1, "lit_ready_after_last", 64'(rdy[1]), 64'd0);
        check(1, "lit_done_plus0", 64'(done_o[1]), 64'd0);
        @(negedge clk);
        check(1, "lit_done_plus1", 64'(done_o[1]), 64'd0);
        check(1, "lit_ready_plus1", 64'(rdy[1]), 64'd0);
        @(negedge clk);
        check(1, "lit_done_plus2", 64'(done_o[1]), 64'd1);
        check_stats(1, 16'd500, 16'd1, 32'd5, 48'd12, 16'd2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conf_int_add_err_monitor.md
CONF_INT_ADD_ERR_MONITOR -- requirements
Module: conf_int_add_err_monitor

Interface
REQ-001 Parameter OP_BITWIDTH, default 32, operand and result width in bits.
REQ-002 Parameter NUM_SAMPLES, default 500, number of operand/result triples per run.
REQ-003 Parameter ERR_THRESH, default 0; an absolute error greater than ERR_THRESH counts as a mismatch.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 racc  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 start  input  1  one-cycle pulse; clears statistics and begins a run.
REQ-007 s_valid  input  1  triple on a, b, d is valid this cycle.
REQ-008 s_ready  output  1  monitor accepts a triple this cycle.
REQ-009 a, b  input  OP_BITWIDTH each  operands that were applied to the adder under test.
REQ-010 d  input  OP_BITWIDTH  adder result aligned with a and b, supplied by the driver.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  run complete; statistics stable.
REQ-013 sample_cnt  output  16  number of accepted triples.
REQ-014 mismatch_cnt  output  16  number of triples whose error exceeds ERR_THRESH.
REQ-015 max_err  output  OP_BITWIDTH  largest absolute error seen.
REQ-016 sum_err  output  48  saturating sum of absolute errors.
REQ-017 first_bad_idx  output  16  index of the first mismatch; 16'hFFFF when there has been no mismatch.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE -> RUN on start; statistics are cleared in the same edge, and first_bad_idx is set to 16'hFFFF.
REQ-020 s_ready SHALL be 1 only in RUN while accepted < NUM_SAMPLES; a triple is accepted when s_valid && s_ready.
REQ-021 Stage 1, registered on acceptance:
- exact = (a + b) mod 2^OP_BITWIDTH, computed as a signed two's-complement value.
- diff = exact - d, computed at OP_BITWIDTH+1 bits signed.
- abs_err = |diff|, truncated to OP_BITWIDTH bits.
- the sample index is captured with the result.
REQ-022 Stage 2, one cycle after stage 1:
- sample_cnt increments by 1.
- sum_err += abs_err, saturating at 2^48-1.
- max_err = max(max_err, abs_err).
- if abs_err > ERR_THRESH, mismatch_cnt increments; first_bad_idx loads the index if it is still 16'hFFFF.
REQ-023 Total latency from acceptance to the statistics update SHALL be 2 cycles; the pipeline accepts one triple per cycle with no bubbles.
REQ-024 RUN -> DRAIN on the edge that accepts triple number NUM_SAMPLES.
REQ-025 DRAIN -> DONE when both pipeline stages are empty, which takes 2 cycles after the last acceptance.
REQ-026 done SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DRAIN.
REQ-027 DONE -> RUN on start, clearing all statistics; DONE holds otherwise.
REQ-028 start in RUN or DRAIN SHALL be ignored.
REQ-029 s_valid outside RUN SHALL be ignored and change no state.
REQ-030 The 16-bit counters SHALL saturate at 16'hFFFF and never wrap.
REQ-031 d = exact SHALL give abs_err 0.
REQ-032 a = 32'h7FFFFFFF, b = 1 SHALL give exact = 32'h80000000, using the wrapped value.

Reset
REQ-033 racc == 0 at a rising edge SHALL force, regardless of state or pipeline contents:
- state IDLE; pipeline emptied.
- s_ready = 0, busy = 0, done = 0.
- all counters and error registers = 0; first_bad_idx = 16'hFFFF.
REQ-034 Reset asserted mid-run SHALL discard in-flight triples; no partial update is visible after reset.
REQ-035 Outputs SHALL hold their reset values until the first start after racc returns to 1.

Verification
REQ-036 Exact match, NUM_SAMPLES=4: four triples with d = a+b -> after done, sample_cnt=4, mismatch_cnt=0, max_err=0, sum_err=0, first_bad_idx=16'hFFFF.
REQ-037 Error injection: triples (10,5,15), (10,5,12), (-3,-4,-7), (100,1,109) -> mismatch_cnt=2, max_err=8, sum_err=11, first_bad_idx=1.
REQ-038 Overflow case: a=32'h7FFFFFFF, b=1, d=32'h80000000 -> abs_err=0, no mismatch.
REQ-039 Back-to-back and gapped input: s_valid toggled randomly over NUM_SAMPLES=500 -> sample_cnt=500.
- done rises exactly 2 cycles after the 500th acceptance.
- s_ready is 0 from that acceptance onward.
REQ-040 Reset mid-run: racc=0 for 20 cycles after 3 accepted triples -> all outputs equal their REQ-033 values; a new start then counts from 0.
REQ-041 Threshold: ERR_THRESH=4 with errors 3, 4 and 5 -> mismatch_cnt=1, first_bad_idx=2, sum_err=12.
